// File: rtl/risc_v_mike_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// risc_v_mike_gpio_ctrl
// Memory-mapped multi-port GPIO controller for the risc_v_mike core. It
// provides per-pin direction, synchronised inputs, edge-detect interrupts
// with write-1-to-clear status, and one level interrupt to the core.
//
// Word address layout: {port_idx, reg_off[2:0]}
//   0 OUT (RW)   1 DIR (RW, 1=output)   2 IN (RO)   3 IRQ_EN (RW)
//   4 IRQ_RISE (RW)   5 IRQ_FALL (RW)   6 IRQ_STAT (R/W1C)   7 reserved
//
// Ports
//   clk            core clock
//   rst            asynchronous active-low reset
//   bus_we/bus_re  single-cycle write / read strobes
//   bus_addr       word address
//   bus_wdata      write data, low PORT_WIDTH bits used
//   bus_rdata      registered read data, zero-extended, held between reads
//   bus_rvalid     high for one cycle, one cycle after bus_re
//   gpio_port_in   raw asynchronous pins, port p at [p*PORT_WIDTH +: PORT_WIDTH]
//   gpio_port_out  OUT register per pin
//   gpio_port_oe   DIR register per pin
//   irq            OR of every IRQ_STAT bit
// ---------------------------------------------------------------------------
module risc_v_mike_gpio_ctrl #(
   parameter int NUM_PORTS   = 4,
   parameter int PORT_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            bus_we,
   input  logic                            bus_re,
   input  logic [ADDR_WIDTH-1:0]           bus_addr,
   input  logic [31:0]                     bus_wdata,
   output logic [31:0]                     bus_rdata,
   output logic                            bus_rvalid,
   input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_in,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_out,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_oe,
   output logic                            irq
);

   localparam int TOTAL_W = NUM_PORTS * PORT_WIDTH;
   localparam int IDX_W   = ADDR_WIDTH - 3;

   localparam logic [2:0] OFF_OUT  = 3'd0;
   localparam logic [2:0] OFF_DIR  = 3'd1;
   localparam logic [2:0] OFF_IN   = 3'd2;
   localparam logic [2:0] OFF_EN   = 3'd3;
   localparam logic [2:0] OFF_RISE = 3'd4;
   localparam logic [2:0] OFF_FALL = 3'd5;
   localparam logic [2:0] OFF_STAT = 3'd6;

   // Register file, one entry per port
   logic [PORT_WIDTH-1:0] out_r      [NUM_PORTS];
   logic [PORT_WIDTH-1:0] dir_r      [NUM_PORTS];
   logic [PORT_WIDTH-1:0] irq_en_r   [NUM_PORTS];
   logic [PORT_WIDTH-1:0] irq_rise_r [NUM_PORTS];
   logic [PORT_WIDTH-1:0] irq_fall_r [NUM_PORTS];
   logic [PORT_WIDTH-1:0] irq_stat_r [NUM_PORTS];
   logic [PORT_WIDTH-1:0] irq_stat_next_s [NUM_PORTS];

   // Input synchroniser chain and edge history
   logic [TOTAL_W-1:0] sync_r [SYNC_STAGES];
   logic [TOTAL_W-1:0] prev_r;
   logic [TOTAL_W-1:0] in_s;
   logic [TOTAL_W-1:0] en_flat_s;
   logic [TOTAL_W-1:0] rise_cfg_flat_s;
   logic [TOTAL_W-1:0] fall_cfg_flat_s;
   logic [TOTAL_W-1:0] stat_flat_s;
   logic [TOTAL_W-1:0] set_s;

   // Bus decode
   logic [IDX_W-1:0]      port_idx_s;
   logic [2:0]            reg_off_s;
   logic [PORT_WIDTH-1:0] wdata_s;
   logic [NUM_PORTS-1:0]  port_sel_s;
   logic [NUM_PORTS-1:0]  wr_out_s;
   logic [NUM_PORTS-1:0]  wr_dir_s;
   logic [NUM_PORTS-1:0]  wr_en_s;
   logic [NUM_PORTS-1:0]  wr_rise_s;
   logic [NUM_PORTS-1:0]  wr_fall_s;
   logic [NUM_PORTS-1:0]  wr_stat_s;
   logic [PORT_WIDTH-1:0] rd_val_s;
   logic [31:0]           rd_word_s;
   logic                  wdata_unused_s;

   assign port_idx_s = bus_addr[ADDR_WIDTH-1:3];
   assign reg_off_s  = bus_addr[2:0];
   assign wdata_s    = bus_wdata[PORT_WIDTH-1:0];
   // Upper write-data bits are architecturally ignored
   assign wdata_unused_s = ^bus_wdata;

   // One-hot port select; an index at or beyond NUM_PORTS selects nothing,
   // which makes such writes no-ops and such reads return zero
   always_comb begin
      port_sel_s = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (32'(port_idx_s) == p) begin
            port_sel_s[p] = 1'b1;
         end else begin
            port_sel_s[p] = 1'b0;
         end
      end
   end

   // Per-register write strobes
   always_comb begin
      wr_out_s  = '0;
      wr_dir_s  = '0;
      wr_en_s   = '0;
      wr_rise_s = '0;
      wr_fall_s = '0;
      wr_stat_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wr_out_s[p]  = bus_we & port_sel_s[p] & (reg_off_s == OFF_OUT);
         wr_dir_s[p]  = bus_we & port_sel_s[p] & (reg_off_s == OFF_DIR);
         wr_en_s[p]   = bus_we & port_sel_s[p] & (reg_off_s == OFF_EN);
         wr_rise_s[p] = bus_we & port_sel_s[p] & (reg_off_s == OFF_RISE);
         wr_fall_s[p] = bus_we & port_sel_s[p] & (reg_off_s == OFF_FALL);
         wr_stat_s[p] = bus_we & port_sel_s[p] & (reg_off_s == OFF_STAT);
      end
   end

   assign in_s = sync_r[SYNC_STAGES-1];

   // Flatten per-port configuration so edge detection works on whole vectors
   always_comb begin
      en_flat_s       = '0;
      rise_cfg_flat_s = '0;
      fall_cfg_flat_s = '0;
      stat_flat_s     = '0;
      gpio_port_out   = '0;
      gpio_port_oe    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         en_flat_s[p*PORT_WIDTH +: PORT_WIDTH]       = irq_en_r[p];
         rise_cfg_flat_s[p*PORT_WIDTH +: PORT_WIDTH] = irq_rise_r[p];
         fall_cfg_flat_s[p*PORT_WIDTH +: PORT_WIDTH] = irq_fall_r[p];
         stat_flat_s[p*PORT_WIDTH +: PORT_WIDTH]     = irq_stat_r[p];
         gpio_port_out[p*PORT_WIDTH +: PORT_WIDTH]   = out_r[p];
         gpio_port_oe[p*PORT_WIDTH +: PORT_WIDTH]    = dir_r[p];
      end
   end

   // Edge events qualified by the per-pin enables
   assign set_s = en_flat_s & (((in_s & ~prev_r) & rise_cfg_flat_s) |
                               ((~in_s & prev_r) & fall_cfg_flat_s));

   // Status next state: a new event overrides a same-cycle W1C on that bit
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         irq_stat_next_s[p] = (irq_stat_r[p] & ~({PORT_WIDTH{wr_stat_s[p]}} & wdata_s))
                            | set_s[p*PORT_WIDTH +: PORT_WIDTH];
      end
   end

   assign irq = |stat_flat_s;

   // Read mux: addressed register value before any same-cycle write
   always_comb begin
      rd_val_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         logic [PORT_WIDTH-1:0] port_val_v;
         case (reg_off_s)
            OFF_OUT:  port_val_v = out_r[p];
            OFF_DIR:  port_val_v = dir_r[p];
            OFF_IN:   port_val_v = in_s[p*PORT_WIDTH +: PORT_WIDTH];
            OFF_EN:   port_val_v = irq_en_r[p];
            OFF_RISE: port_val_v = irq_rise_r[p];
            OFF_FALL: port_val_v = irq_fall_r[p];
            OFF_STAT: port_val_v = irq_stat_r[p];
            default:  port_val_v = '0;
         endcase
         rd_val_s = rd_val_s | ({PORT_WIDTH{port_sel_s[p]}} & port_val_v);
      end
   end

   // Zero-extend the selected value to the bus width
   always_comb begin
      rd_word_s = '0;
      rd_word_s[PORT_WIDTH-1:0] = rd_val_s;
   end

   // Input synchroniser chain and one-cycle edge history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_r[s] <= '0;
         end
         prev_r <= '0;
      end else begin
         sync_r[0] <= gpio_port_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_r[s] <= sync_r[s-1];
         end
         prev_r <= in_s;
      end
   end

   // Configuration and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            out_r[p]      <= '0;
            dir_r[p]      <= '0;
            irq_en_r[p]   <= '0;
            irq_rise_r[p] <= '0;
            irq_fall_r[p] <= '0;
            irq_stat_r[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_out_s[p])  out_r[p]      <= wdata_s;
            if (wr_dir_s[p])  dir_r[p]      <= wdata_s;
            if (wr_en_s[p])   irq_en_r[p]   <= wdata_s;
            if (wr_rise_s[p]) irq_rise_r[p] <= wdata_s;
            if (wr_fall_s[p]) irq_fall_r[p] <= wdata_s;
            irq_stat_r[p] <= irq_stat_next_s[p];
         end
      end
   end

   // Registered read response; data holds while no read is returning
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_rdata  <= 32'h0000_0000;
         bus_rvalid <= 1'b0;
      end else begin
         bus_rvalid <= bus_re;
         if (bus_re) begin
            bus_rdata <= rd_word_s;
         end
      end
   end

endmodule

// File: tb/tb_risc_v_mike_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_risc_v_mike_gpio_ctrl
// Self-checking bench for risc_v_mike_gpio_ctrl: a table of bus accesses with
// hand-derived expectations, hand-written latency / race / reset sequences,
// and a randomized phase compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_risc_v_mike_gpio_ctrl;

   localparam int NP = 4;
   localparam int PW = 8;
   localparam int SS = 2;
   localparam int AW = 8;
   localparam int TW = NP * PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          bus_we;
   logic          bus_re;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic [31:0]   bus_rdata;
   logic          bus_rvalid;
   logic [TW-1:0] gpio_port_in;
   logic [TW-1:0] gpio_port_out;
   logic [TW-1:0] gpio_port_oe;
   logic          irq;

   int checks = 0;
   int errors = 0;

   risc_v_mike_gpio_ctrl #(
      .NUM_PORTS(NP), .PORT_WIDTH(PW), .SYNC_STAGES(SS), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .bus_we(bus_we), .bus_re(bus_re),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_rvalid(bus_rvalid), .gpio_port_in(gpio_port_in),
      .gpio_port_out(gpio_port_out), .gpio_port_oe(gpio_port_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // m_reg[port][offset] holds the programmable registers (offsets 0,1,3..6).
   // m_ph keeps the pin vectors seen at the last SS+1 clock edges, oldest
   // first; the synchronised IN view is m_ph[1] and the previous IN is m_ph[0].
   logic [PW-1:0] m_reg [NP][8];
   logic [TW-1:0] m_ph [SS+1];
   logic [31:0]   m_rdata;
   logic          m_rvalid;

   function automatic void model_reset();
      for (int p = 0; p < NP; p++)
         for (int o = 0; o < 8; o++) m_reg[p][o] = '0;
      for (int i = 0; i <= SS; i++) m_ph[i] = '0;
      m_rdata  = 32'h0;
      m_rvalid = 1'b0;
   endfunction

   function automatic void model_edge();
      int p, o;
      logic [PW-1:0] rv, nw, od, wd;
      logic [PW-1:0] setv [NP];
      p  = int'(bus_addr[AW-1:3]);
      o  = int'(bus_addr[2:0]);
      wd = bus_wdata[PW-1:0];
      rv = '0;
      if (bus_re && p < NP) begin
         if (o == 2) rv = m_ph[1][p*PW +: PW];
         else if (o == 7) rv = '0;
         else rv = m_reg[p][o];
      end
      for (int q = 0; q < NP; q++) begin
         nw = m_ph[1][q*PW +: PW];
         od = m_ph[0][q*PW +: PW];
         setv[q] = m_reg[q][3] & (((nw & ~od) & m_reg[q][4]) | ((~nw & od) & m_reg[q][5]));
      end
      if (bus_we && p < NP) begin
         case (o)
            0, 1, 3, 4, 5: m_reg[p][o] = wd;
            6:             m_reg[p][6] = m_reg[p][6] & ~wd;
            default:       ;
         endcase
      end
      for (int q = 0; q < NP; q++) m_reg[q][6] = m_reg[q][6] | setv[q];
      for (int i = 0; i < SS; i++) m_ph[i] = m_ph[i+1];
      m_ph[SS] = gpio_port_in;
      m_rvalid = bus_re;
      if (bus_re) m_rdata = {24'h0, rv};
   endfunction

   function automatic logic [TW-1:0] m_field(int off);
      logic [TW-1:0] r;
      r = '0;
      for (int p = 0; p < NP; p++) r[p*PW +: PW] = m_reg[p][off];
      return r;
   endfunction

   function automatic logic m_irq();
      logic r;
      r = 1'b0;
      for (int p = 0; p < NP; p++) r = r | (|m_reg[p][6]);
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic re, input logic [7:0] a, input logic [31:0] d);
      bus_we    = we;
      bus_re    = re;
      bus_addr  = a;
      bus_wdata = d;
   endtask

   // One clock: advance the model at the edge, compare just after it
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("m_rdata",  bus_rdata, m_rdata);
      chk("m_rvalid", 32'(bus_rvalid), 32'(m_rvalid));
      chk("m_out",    gpio_port_out, m_field(0));
      chk("m_oe",     gpio_port_oe, m_field(1));
      chk("m_irq",    32'(irq), 32'(m_irq()));
   endtask

   task automatic do_reset(input logic [TW-1:0] pins);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      gpio_port_in = pins;
      rst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irq",    32'(irq), 32'h0);
      chk("rst_rvalid", 32'(bus_rvalid), 32'h0);
      chk("rst_rdata",  bus_rdata, 32'h0);
      chk("rst_oe",     gpio_port_oe, 32'h0);
      chk("rst_out",    gpio_port_out, 32'h0);
      rst = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        rv;
      logic [31:0] rd;
      logic [31:0] out;
      logic [31:0] oe;
   } vec_t;

   vec_t tbl [17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 8'h09, 32'h0F, 1'b0, 32'h00, 32'h0000_0000, 32'h0000_0F00};
      tbl[1]  = '{1'b1, 1'b0, 8'h08, 32'hA5, 1'b0, 32'h00, 32'h0000_A500, 32'h0000_0F00};
      tbl[2]  = '{1'b0, 1'b1, 8'h08, 32'h00, 1'b1, 32'hA5, 32'h0000_A500, 32'h0000_0F00};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 32'h00, 1'b0, 32'hA5, 32'h0000_A500, 32'h0000_0F00};
      tbl[4]  = '{1'b0, 1'b1, 8'h0F, 32'h00, 1'b1, 32'h00, 32'h0000_A500, 32'h0000_0F00};
      tbl[5]  = '{1'b0, 1'b1, 8'h09, 32'h00, 1'b1, 32'h0F, 32'h0000_A500, 32'h0000_0F00};
      tbl[6]  = '{1'b1, 1'b0, 8'h20, 32'hFF, 1'b0, 32'h0F, 32'h0000_A500, 32'h0000_0F00};
      tbl[7]  = '{1'b0, 1'b1, 8'h20, 32'h00, 1'b1, 32'h00, 32'h0000_A500, 32'h0000_0F00};
      tbl[8]  = '{1'b0, 1'b1, 8'h09, 32'h00, 1'b1, 32'h0F, 32'h0000_A500, 32'h0000_0F00};
      tbl[9]  = '{1'b1, 1'b0, 8'h0F, 32'h77, 1'b0, 32'h0F, 32'h0000_A500, 32'h0000_0F00};
      tbl[10] = '{1'b0, 1'b1, 8'h0F, 32'h00, 1'b1, 32'h00, 32'h0000_A500, 32'h0000_0F00};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 32'h11, 1'b0, 32'h00, 32'h0000_A511, 32'h0000_0F00};
      tbl[12] = '{1'b1, 1'b1, 8'h00, 32'h22, 1'b1, 32'h11, 32'h0000_A522, 32'h0000_0F00};
      tbl[13] = '{1'b0, 1'b1, 8'h00, 32'h00, 1'b1, 32'h22, 32'h0000_A522, 32'h0000_0F00};
      tbl[14] = '{1'b1, 1'b0, 8'h0A, 32'h55, 1'b0, 32'h22, 32'h0000_A522, 32'h0000_0F00};
      tbl[15] = '{1'b0, 1'b1, 8'h0A, 32'h00, 1'b1, 32'h00, 32'h0000_A522, 32'h0000_0F00};
      tbl[16] = '{1'b0, 1'b1, 8'h08, 32'h00, 1'b1, 32'hA5, 32'h0000_A522, 32'h0000_0F00};

      // T1: reset with all pins high, then read every register
      do_reset({TW{1'b1}});
      repeat (SS + 2) tick();
      for (int p = 0; p < NP; p++) begin
         for (int o = 0; o < 8; o++) begin
            drive(1'b0, 1'b1, 8'(p * 8 + o), 32'h0);
            tick();
            chk("t1_reg", bus_rdata, (o == 2) ? 32'hFF : 32'h0);
            chk("t1_rvalid", 32'(bus_rvalid), 32'h1);
         end
      end
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      chk("t1_irq", 32'(irq), 32'h0);
      chk("t1_oe", gpio_port_oe, 32'h0);

      // T2/T5: table of accesses, pins low
      do_reset({TW{1'b0}});
      repeat (SS + 2) tick();
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
         tick();
         chk("tbl_rvalid", 32'(bus_rvalid), 32'(tbl[i].rv));
         chk("tbl_rdata",  bus_rdata, tbl[i].rd);
         chk("tbl_out",    gpio_port_out, tbl[i].out);
         chk("tbl_oe",     gpio_port_oe, tbl[i].oe);
      end

      // T3: rising edge on port0 pin0, exact latency, falling edge ignored
      drive(1'b1, 1'b0, 8'h03, 32'h01); tick();
      drive(1'b1, 1'b0, 8'h04, 32'h01); tick();
      drive(1'b0, 1'b0, 8'h00, 32'h00); tick();
      gpio_port_in[0] = 1'b1;
      for (int k = 0; k < SS; k++) begin
         tick();
         chk("t3_irq_early", 32'(irq), 32'h0);
      end
      tick();
      chk("t3_irq_set", 32'(irq), 32'h1);
      gpio_port_in[0] = 1'b0;
      repeat (SS + 3) tick();
      drive(1'b0, 1'b1, 8'h06, 32'h0); tick();
      chk("t3_stat_after_fall", bus_rdata, 32'h01);
      drive(1'b1, 1'b0, 8'h06, 32'h01); tick();
      chk("t3_w1c_irq", 32'(irq), 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);

      // T4: both-edge on port3 pin7 and W1C racing a new edge
      drive(1'b1, 1'b0, 8'h1B, 32'h80); tick();
      drive(1'b1, 1'b0, 8'h1C, 32'h80); tick();
      drive(1'b1, 1'b0, 8'h1D, 32'h80); tick();
      drive(1'b0, 1'b0, 8'h00, 32'h00);
      gpio_port_in[31] = 1'b1;
      repeat (SS + 1) tick();
      chk("t4_rise", 32'(irq), 32'h1);
      gpio_port_in[31] = 1'b0;
      for (int k = 0; k < SS; k++) tick();
      drive(1'b1, 1'b0, 8'h1E, 32'h80); tick();
      chk("t4_race", 32'(irq), 32'h1);
      drive(1'b0, 1'b0, 8'h00, 32'h00); tick();
      chk("t4_race_hold", 32'(irq), 32'h1);
      drive(1'b1, 1'b0, 8'h1E, 32'h80); tick();
      chk("t4_w1c", 32'(irq), 32'h0);
      drive(1'b0, 1'b1, 8'h1E, 32'h00); tick();
      chk("t4_stat", bus_rdata, 32'h00);

      // T6: reset while IRQ_STAT is full and a read is in flight
      drive(1'b1, 1'b0, 8'h03, 32'hFF); tick();
      drive(1'b1, 1'b0, 8'h04, 32'hFF); tick();
      drive(1'b0, 1'b0, 8'h00, 32'h00);
      gpio_port_in[7:0] = 8'hFF;
      repeat (SS + 2) tick();
      drive(1'b0, 1'b1, 8'h06, 32'h0); tick();
      chk("t6_stat_full", bus_rdata, 32'hFF);
      chk("t6_irq_before", 32'(irq), 32'h1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("t6_irq_async",    32'(irq), 32'h0);
      chk("t6_rvalid_async", 32'(bus_rvalid), 32'h0);
      chk("t6_rdata_async",  bus_rdata, 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t6_no_rvalid", 32'(bus_rvalid), 32'h0);
      end
      drive(1'b0, 1'b1, 8'h06, 32'h0); tick();
      chk("t6_stat_clear", bus_rdata, 32'h00);
      chk("t6_irq_clear", 32'(irq), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               8'($urandom_range(0, 39)), $urandom);
         if ($urandom_range(0, 3) == 0) gpio_port_in = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
